// File: rtl/vmem_pkg.sv
// Shared types and geometry helpers for the vector load/store splitter.
package vmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    function automatic int line_bytes(input int block_w);
        return block_w / 8;
    endfunction

endpackage

// File: rtl/vchunk_calc.sv
// Largest chunk starting at addr that neither exceeds the remaining bytes
// nor crosses a cache line boundary (LINE_BYTES must be a power of two).
module vchunk_calc #(
    parameter int ADDR_W     = 32,
    parameter int SIZE_W     = 6,
    parameter int LINE_BYTES = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [SIZE_W:0]   remaining,
    output logic [SIZE_W:0]   chunk
);

    localparam int CNT_W = SIZE_W + 1;

    logic [ADDR_W-1:0] line_off;
    logic [CNT_W-1:0]  offset;
    logic [CNT_W-1:0]  space;

    always_comb begin
        line_off = addr & ADDR_W'(LINE_BYTES - 1);
        offset   = CNT_W'(line_off);
        space    = CNT_W'(LINE_BYTES) - offset;
        chunk    = (remaining < space) ? remaining : space;
    end

endmodule

// File: rtl/vldst_splitter.sv
// Splits a vector load/store into line-bounded cache accesses, one load chunk
// in flight at a time, and reassembles load data into a single completion.
module vldst_splitter
    import vmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int BLOCK_W   = 256,
    parameter int SIZE_W    = 6,
    parameter int MICROOP_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [SIZE_W-1:0]    req_size_i,
    input  logic                 req_store_i,
    input  logic [DATA_W-1:0]    req_data_i,
    input  logic [MICROOP_W-1:0] req_microop_i,
    output logic                 cache_valid_o,
    input  logic                 cache_ready_i,
    output logic [ADDR_W-1:0]    cache_addr_o,
    output logic [SIZE_W-1:0]    cache_size_o,
    output logic                 cache_store_o,
    output logic [DATA_W-1:0]    cache_data_o,
    output logic [MICROOP_W-1:0] cache_microop_o,
    input  logic                 resp_valid_i,
    input  logic [DATA_W-1:0]    resp_data_i,
    output logic                 done_valid_o,
    input  logic                 done_ready_i,
    output logic                 done_store_o,
    output logic [DATA_W-1:0]    done_data_o,
    output state_t               state_o
);

    localparam int LINE_BYTES = line_bytes(BLOCK_W);
    localparam int CNT_W      = SIZE_W + 1;

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; a valid source holds its payload until then.
    state_t                state;
    logic [ADDR_W-1:0]     base_q;
    logic [CNT_W-1:0]      size_q;
    logic                  store_q;
    logic [DATA_W-1:0]     data_q;
    logic [MICROOP_W-1:0]  microop_q;
    logic [CNT_W-1:0]      bytes_done;
    logic [DATA_W-1:0]     acc;

    logic [ADDR_W-1:0]     cur_addr;
    logic [CNT_W-1:0]      remaining;
    logic [CNT_W-1:0]      chunk;
    logic [CNT_W+2:0]      bit_off;
    logic [DATA_W-1:0]     chunk_mask;
    logic                  last_chunk;

    vchunk_calc #(
        .ADDR_W     (ADDR_W),
        .SIZE_W     (SIZE_W),
        .LINE_BYTES (LINE_BYTES)
    ) u_chunk (
        .addr      (cur_addr),
        .remaining (remaining),
        .chunk     (chunk)
    );

    always_comb begin
        cur_addr   = base_q + ADDR_W'(bytes_done);
        remaining  = size_q - bytes_done;
        bit_off    = {bytes_done, 3'b000};
        last_chunk = (remaining == chunk);
        chunk_mask = '0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (CNT_W'(i) < chunk) chunk_mask[8*i +: 8] = 8'hFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            size_q     <= '0;
            store_q    <= 1'b0;
            data_q     <= '0;
            microop_q  <= '0;
            bytes_done <= '0;
            acc        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        base_q     <= req_addr_i;
                        size_q     <= {1'b0, req_size_i};
                        store_q    <= req_store_i;
                        data_q     <= req_data_i;
                        microop_q  <= req_microop_i;
                        bytes_done <= '0;
                        acc        <= '0;
                        state      <= (req_size_i == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cache_ready_i) begin
                        if (store_q) begin
                            bytes_done <= bytes_done + chunk;
                            state      <= last_chunk ? ST_DONE : ST_ISSUE;
                        end else begin
                            state <= ST_WAIT_RESP;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    // bytes_done is frozen here, so chunk still describes the outstanding load
                    if (resp_valid_i) begin
                        acc        <= acc | ((resp_data_i & chunk_mask) << bit_off);
                        bytes_done <= bytes_done + chunk;
                        state      <= last_chunk ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    if (done_ready_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o     = (state == ST_IDLE) && !rst;
        cache_valid_o   = (state == ST_ISSUE);
        cache_addr_o    = cache_valid_o ? cur_addr : '0;
        cache_size_o    = cache_valid_o ? SIZE_W'(chunk) : '0;
        cache_store_o   = cache_valid_o && store_q;
        cache_data_o    = cache_valid_o ? ((data_q >> bit_off) & chunk_mask) : '0;
        cache_microop_o = cache_valid_o ? microop_q : '0;
        done_valid_o    = (state == ST_DONE);
        done_store_o    = done_valid_o && store_q;
        done_data_o     = done_valid_o ? acc : '0;
        state_o         = state;
    end

endmodule

// File: tb/tb_vldst_splitter.sv
// Directed bench for vldst_splitter: aligned load, line-crossing load with
// stalls, line-crossing store, reset during a load, and an empty request.
module tb_vldst_splitter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 256;
    localparam int SIZE_W    = 6;
    localparam int MICROOP_W = 7;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [ADDR_W-1:0]    req_addr_i;
    logic [SIZE_W-1:0]    req_size_i;
    logic                 req_store_i;
    logic [DATA_W-1:0]    req_data_i;
    logic [MICROOP_W-1:0] req_microop_i;
    logic                 cache_valid_o;
    logic                 cache_ready_i;
    logic [ADDR_W-1:0]    cache_addr_o;
    logic [SIZE_W-1:0]    cache_size_o;
    logic                 cache_store_o;
    logic [DATA_W-1:0]    cache_data_o;
    logic [MICROOP_W-1:0] cache_microop_o;
    logic                 resp_valid_i;
    logic [DATA_W-1:0]    resp_data_i;
    logic                 done_valid_o;
    logic                 done_ready_i;
    logic                 done_store_o;
    logic [DATA_W-1:0]    done_data_o;
    logic [1:0]           dbg_state;

    int n_cmp = 0;
    int n_mis = 0;

    vldst_splitter dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_size_i      (req_size_i),
        .req_store_i     (req_store_i),
        .req_data_i      (req_data_i),
        .req_microop_i   (req_microop_i),
        .cache_valid_o   (cache_valid_o),
        .cache_ready_i   (cache_ready_i),
        .cache_addr_o    (cache_addr_o),
        .cache_size_o    (cache_size_o),
        .cache_store_o   (cache_store_o),
        .cache_data_o    (cache_data_o),
        .cache_microop_o (cache_microop_o),
        .resp_valid_i    (resp_valid_i),
        .resp_data_i     (resp_data_i),
        .done_valid_o    (done_valid_o),
        .done_ready_i    (done_ready_i),
        .done_store_o    (done_store_o),
        .done_data_o     (done_data_o),
        .state_o         (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [ADDR_W-1:0] addr, input logic [SIZE_W-1:0] size,
                             input logic store, input logic [DATA_W-1:0] data,
                             input logic [MICROOP_W-1:0] uop);
        req_valid_i   = 1'b1;
        req_addr_i    = addr;
        req_size_i    = size;
        req_store_i   = store;
        req_data_i    = data;
        req_microop_i = uop;
        tick();
        req_valid_i   = 1'b0;
    endtask

    task automatic finish_done();
        done_ready_i = 1'b1;
        tick();
        done_ready_i = 1'b0;
    endtask

    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] junk;
    logic [DATA_W-1:0] snap_data;
    logic [ADDR_W-1:0] snap_addr;
    logic [SIZE_W-1:0] snap_size;

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_addr_i = '0; req_size_i = '0; req_store_i = 1'b0;
        req_data_i = '0; req_microop_i = '0; cache_ready_i = 1'b0;
        resp_valid_i = 1'b0; resp_data_i = '0; done_ready_i = 1'b0;
        for (int i = 0; i < DATA_W / 8; i++) r1[8*i +: 8] = 8'(i * 7 + 3);
        junk = {8{32'hA5A55A5A}};

        // reset state
        tick(); tick();
        check("rst_req_ready", req_ready_o, 0);
        check("rst_cache_valid", cache_valid_o, 0);
        check("rst_done_valid", done_valid_o, 0);
        check("rst_cache_addr", cache_addr_o, 0);
        check("rst_cache_data", cache_data_o, 0);
        check("rst_done_data", done_data_o, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready_o, 1);

        // aligned 32-byte load: single chunk
        cache_ready_i = 1'b1;
        drive_req(32'h100, 6'd32, 1'b0, junk, 7'h5A);
        check("ld1_valid", cache_valid_o, 1);
        check("ld1_addr", cache_addr_o, 256'h100);
        check("ld1_size", cache_size_o, 256'd32);
        check("ld1_store", cache_store_o, 0);
        check("ld1_uop", cache_microop_o, 256'h5A);
        check("ld1_req_ready", req_ready_o, 0);
        tick();
        cache_ready_i = 1'b0;
        check("ld1_wait_valid", cache_valid_o, 0);
        check("ld1_wait_state", dbg_state, 256'd2);
        resp_valid_i = 1'b1; resp_data_i = r1;
        tick();
        resp_valid_i = 1'b0;
        check("ld1_done_valid", done_valid_o, 1);
        check("ld1_done_data", done_data_o, r1);
        check("ld1_done_store", done_store_o, 0);
        finish_done();
        check("ld1_idle_ready", req_ready_o, 1);
        check("ld1_idle_done", done_valid_o, 0);

        // line-crossing load with a 3-cycle stall and a stray response
        drive_req(32'h11C, 6'd16, 1'b0, junk, 7'h03);
        check("ld2_c1_addr", cache_addr_o, 256'h11C);
        check("ld2_c1_size", cache_size_o, 256'd4);
        snap_addr = cache_addr_o; snap_size = cache_size_o; snap_data = cache_data_o;
        resp_valid_i = 1'b1; resp_data_i = '1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", cache_valid_o, 1);
            check("stall_addr", cache_addr_o, 256'(snap_addr));
            check("stall_size", cache_size_o, 256'(snap_size));
            check("stall_data", cache_data_o, snap_data);
        end
        resp_valid_i = 1'b0;
        cache_ready_i = 1'b1;
        tick();
        cache_ready_i = 1'b0;
        check("ld2_wait1", cache_valid_o, 0);
        resp_data_i = '1; resp_data_i[31:0] = 32'hDDCCBBAA; resp_valid_i = 1'b1;
        tick();
        resp_valid_i = 1'b0;
        check("ld2_c2_valid", cache_valid_o, 1);
        check("ld2_c2_addr", cache_addr_o, 256'h120);
        check("ld2_c2_size", cache_size_o, 256'd12);
        cache_ready_i = 1'b1;
        tick();
        cache_ready_i = 1'b0;
        resp_data_i = {DATA_W/8{8'hEE}};
        resp_data_i[95:0] = 96'h0C0B0A09_08070605_04030201;
        resp_valid_i = 1'b1;
        tick();
        resp_valid_i = 1'b0;
        check("ld2_done_valid", done_valid_o, 1);
        check("ld2_done_data", done_data_o, 256'h0C0B0A09_08070605_04030201_DDCCBBAA);
        tick();
        check("ld2_done_hold", done_valid_o, 1);
        finish_done();

        // line-crossing store: no responses needed
        cache_ready_i = 1'b1;
        r1 = '1; r1[63:0] = 64'h17161514_13121110;
        drive_req(32'h13E, 6'd8, 1'b1, r1, 7'h11);
        check("st_c1_addr", cache_addr_o, 256'h13E);
        check("st_c1_size", cache_size_o, 256'd2);
        check("st_c1_data", cache_data_o, 256'h1110);
        check("st_c1_store", cache_store_o, 1);
        tick();
        check("st_c2_valid", cache_valid_o, 1);
        check("st_c2_addr", cache_addr_o, 256'h140);
        check("st_c2_size", cache_size_o, 256'd6);
        check("st_c2_data", cache_data_o, 256'h171615141312);
        tick();
        cache_ready_i = 1'b0;
        check("st_c_idle", cache_valid_o, 0);
        check("st_done_valid", done_valid_o, 1);
        check("st_done_store", done_store_o, 1);
        check("st_done_data", done_data_o, 0);
        finish_done();

        // reset while waiting for a load response, then a late response
        cache_ready_i = 1'b1;
        drive_req(32'h100, 6'd32, 1'b0, junk, 7'h01);
        tick();
        cache_ready_i = 1'b0;
        check("rstw_state", dbg_state, 256'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resp_valid_i = 1'b1; resp_data_i = junk;
        tick();
        resp_valid_i = 1'b0;
        check("rstw_done", done_valid_o, 0);
        check("rstw_ready", req_ready_o, 1);
        check("rstw_cache", cache_valid_o, 0);
        tick();
        check("rstw_done2", done_valid_o, 0);

        // empty request completes immediately
        drive_req(32'h200, 6'd0, 1'b0, junk, 7'h00);
        check("sz0_cache", cache_valid_o, 0);
        check("sz0_done", done_valid_o, 1);
        check("sz0_data", done_data_o, 0);
        check("sz0_store", done_store_o, 0);
        finish_done();
        check("sz0_ready", req_ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
